// File: rtl/ram_rd_pkg.sv
// Shared types and sizing for the RAM stream reader.
package ram_rd_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FIN} rd_state_t;

  localparam int unsigned SKID_DEPTH = 2;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry FIFO holding returned RAM words until the stream sink takes them.
module stream_skid_buf
  import ram_rd_pkg::*;
#(
  parameter int unsigned W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [SKID_DEPTH];
  logic         head_q;
  logic [1:0]   count_q;
  logic         tail;

  // With two entries the tail is the head when empty or full, the other slot otherwise.
  assign tail    = head_q ^ count_q[0];
  assign data_o  = mem_q[head_q];
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < SKID_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q  <= 1'b0;
      count_q <= '0;
    end else begin
      assert (!(push_i && !pop_i && count_q == 2'(SKID_DEPTH)));
      assert (!(pop_i && count_q == 2'd0));
      if (push_i) begin
        mem_q[tail] <= data_i;
      end
      if (pop_i) begin
        head_q <= ~head_q;
      end
      count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

endmodule

// File: rtl/ram_stream_reader.sv
// Burst reader for the dual-port RAM: issues reads, absorbs the one-cycle
// read latency and streams the words out with full backpressure.
module ram_stream_reader
  import ram_rd_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    start_addr,
  input  logic [LW-1:0]    length,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [AW-1:0]    rd_addr,
  input  logic [WIDTH-1:0] rd_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last
);

  rd_state_t     state_q;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] issue_left_q, remaining_q;
  logic          inflight_q, last_inflight_q;
  logic [1:0]    sb_count;
  logic [WIDTH:0] sb_dout;
  logic          pop;
  logic [2:0]    occ;

  stream_skid_buf #(.W(WIDTH + 1)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .push_i  (inflight_q),
    .data_i  ({last_inflight_q, rd_data}),
    .pop_i   (pop),
    .data_o  (sb_dout),
    .count_o (sb_count)
  );

  assign m_valid         = (sb_count != 2'd0);
  assign {m_last, m_data} = sb_dout;
  assign pop             = m_valid && m_ready;
  assign occ             = {1'b0, sb_count} + {2'b0, inflight_q};
  // Credit test (occ - pop < 2) written as occ < 2 + pop to stay unsigned.
  assign rd_en   = (state_q == RUN) && (issue_left_q != '0) && (occ < (3'd2 + {2'b0, pop}));
  assign rd_addr = addr_q;
  assign busy    = (state_q == RUN);
  assign done    = (state_q == FIN);
  assign addr_d  = (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + AW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      issue_left_q    <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      last_inflight_q <= 1'b0;
    end else begin
      assert (!(state_q == IDLE && start && length > LW'(DEPTH)));
      assert (!(pop && (m_last != (remaining_q == LW'(1)))));
      inflight_q      <= rd_en;
      last_inflight_q <= rd_en && (issue_left_q == LW'(1));
      case (state_q)
        IDLE: begin
          if (start) begin
            if (length != '0) begin
              addr_q       <= start_addr;
              issue_left_q <= length;
              remaining_q  <= length;
              state_q      <= RUN;
            end else begin
              state_q <= FIN;
            end
          end
        end
        RUN: begin
          if (rd_en) begin
            issue_left_q <= issue_left_q - LW'(1);
            addr_q       <= addr_d;
          end
          if (pop) begin
            remaining_q <= remaining_q - LW'(1);
            if (m_last) begin
              state_q <= FIN;
            end
          end
        end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader with a behavioural one-cycle-latency RAM.
module tb_ram_stream_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] start_addr;
  logic [4:0] length;
  logic       busy, done, rd_en;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       m_valid, m_ready, m_last;
  logic [7:0] m_data;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem [16];
  logic [3:0] iss_q [$];
  logic [8:0] beat_q [$];
  int         iss_tot, pop_tot;
  logic       prev_stall;
  logic [8:0] prev_head;

  ram_stream_reader #(.DEPTH(16), .WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'(i + 16);
    rd_data = '0;
  end

  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: record issues and beats, check stall stability and outstanding reads.
  always @(posedge clk) begin
    if (rst) begin
      iss_tot    = 0;
      pop_tot    = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", {31'b0, m_valid}, 32'd1);
        chk("stall_stable", {23'b0, m_last, m_data}, {23'b0, prev_head});
      end
      prev_stall = m_valid && !m_ready;
      prev_head  = {m_last, m_data};
      if (rd_en) begin
        iss_q.push_back(rd_addr);
        iss_tot++;
      end
      if (m_valid && m_ready) begin
        beat_q.push_back({m_last, m_data});
        pop_tot++;
      end
      if (iss_tot - pop_tot > 2) chk("outstanding", iss_tot - pop_tot, 2);
    end
  end

  task automatic burst(input int a, input int n, input logic [31:0] pat,
                       input int restart_at, output int dcyc, output logic en0);
    iss_q.delete();
    beat_q.delete();
    dcyc = -1;
    en0  = 1'b0;
    @(negedge clk);
    start = 1'b1; start_addr = 4'(a); length = 5'(n); m_ready = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      start = (k == restart_at);
      if (k == restart_at) begin
        start_addr = 4'd9; length = 5'd2;
      end
      m_ready = pat[k % 32];
      #1;
      if (k == 0) en0 = rd_en;
      if (done) begin
        dcyc = k + 1;
        chk("busy_in_fin", {31'b0, busy}, 32'd0);
        break;
      end
    end
    if (dcyc < 0) chk("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
    start = 1'b0; m_ready = 1'b1;
    #1;
    chk("done_one_cycle", {31'b0, done}, 32'd0);
  endtask

  task automatic chk_stream(input string tag, input int a, input int n);
    int ea;
    chk({tag, "_nissue"}, iss_q.size(), n);
    chk({tag, "_nbeat"}, beat_q.size(), n);
    for (int i = 0; i < n; i++) begin
      ea = (a + i) % 16;
      if (i < iss_q.size()) chk({tag, "_addr"}, {28'b0, iss_q[i]}, ea);
      if (i < beat_q.size())
        chk({tag, "_beat"}, {23'b0, beat_q[i]}, {23'b0, (i == n - 1), 8'(ea + 16)});
    end
  endtask

  initial begin
    int   dc;
    logic e0;
    rst = 1'b1; start = 1'b0; start_addr = '0; length = '0; m_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_outputs", {23'b0, busy, done, rd_en, rd_addr, m_valid, m_last},
        32'd0);
    chk("rst_mdata", {24'b0, m_data}, 32'd0);

    // addr 3, len 4, free-running sink: done 7 cycles after start
    burst(3, 4, 32'hFFFF_FFFF, -1, dc, e0);
    chk("b1_rden_cycle0", {31'b0, e0}, 32'd1);
    chk("b1_done_cycle", dc, 7);
    chk("b1_first", {23'b0, beat_q[0]}, 32'h013);
    chk("b1_last", {23'b0, beat_q[3]}, 32'h116);
    chk_stream("b1", 3, 4);

    // wrap: addr 14, len 5 -> 14,15,0,1,2
    burst(14, 5, 32'hFFFF_FFFF, -1, dc, e0);
    chk("b2_done_cycle", dc, 8);
    chk_stream("b2", 14, 5);

    // backpressure: ready 1,0,0,1,0,1,0,1...
    burst(7, 6, 32'hAAAA_AAA9, -1, dc, e0);
    chk_stream("b3", 7, 6);

    // full-depth burst wrapping from addr 5
    burst(5, 16, 32'hFFFF_FFFF, -1, dc, e0);
    chk("b4_done_cycle", dc, 19);
    chk_stream("b4", 5, 16);

    // length 0: straight to FIN, no reads, no beats
    burst(4, 0, 32'hFFFF_FFFF, -1, dc, e0);
    chk("b5_done_cycle", dc, 1);
    chk("b5_rden", {31'b0, e0}, 32'd0);
    chk_stream("b5", 4, 0);

    // start re-pulsed while busy is ignored, then a fresh burst runs normally
    burst(0, 3, 32'hFFFF_FFFF, 1, dc, e0);
    chk("b6_done_cycle", dc, 6);
    chk_stream("b6", 0, 3);
    burst(9, 2, 32'hFFFF_FFFF, -1, dc, e0);
    chk("b7_done_cycle", dc, 5);
    chk_stream("b7", 9, 2);

    // reset mid-burst with a read in flight
    iss_q.delete();
    beat_q.delete();
    @(negedge clk);
    start = 1'b1; start_addr = 4'd5; length = 5'd4; m_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_outputs", {23'b0, busy, done, rd_en, rd_addr, m_valid, m_last},
        32'd0);
    chk("midrst_mdata", {24'b0, m_data}, 32'd0);
    m_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("midrst_no_stale", beat_q.size() + {31'b0, m_valid}, 32'd0);
    burst(2, 2, 32'hFFFF_FFFF, -1, dc, e0);
    chk("b8_done_cycle", dc, 5);
    chk_stream("b8", 2, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
